// File: rtl/keypad_emulator.sv
// keypad_emulator: emulates one 4x4 matrix keypad switch press (bounce, hold, release bounce, gap); ports CLK/RST, key_valid/key_code/key_ready handshake, cancel, row strobes V in, column returns H out, busy, done
module keypad_emulator #(
  parameter int HOLD_CYC      = 200000,
  parameter int GAP_CYC       = 200000,
  parameter int BOUNCE_CYC    = 20000,
  parameter int BOUNCE_TOGGLE = 2500,
  parameter int CW            = 24
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  input  logic       cancel,
  input  logic [3:0] V,
  output logic [3:0] H,
  output logic       busy,
  output logic       done
);
  localparam logic [2:0] IDLE = 3'd0, BIN = 3'd1, HOLD = 3'd2, BOUT = 3'd3, GAP = 3'd4;
  localparam logic [CW-1:0] BL = CW'(BOUNCE_CYC - 1);
  localparam logic [CW-1:0] HL = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] GL = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TL = CW'(BOUNCE_TOGGLE - 1);
  logic [2:0] state, nxt;
  logic [CW-1:0] cnt, tcnt, lim;
  logic contact, bounce, last;
  logic [1:0] r, c;
  always_comb begin
    bounce = state == BIN || state == BOUT;
    lim = bounce ? BL : state == HOLD ? HL : GL;
    last = cnt == lim;
    nxt = state == BIN ? HOLD :
          state == HOLD ? (BOUNCE_CYC == 0 ? GAP : BOUT) :
          state == BOUT ? GAP : IDLE;
    key_ready = state == IDLE;
    busy = ~key_ready;
    done = state == GAP && cnt == GL;
    H = (contact && !V[r]) ? ~(4'b0001 << c) : 4'hF;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      contact <= 1'b0;
      r <= 2'd0;
      c <= 2'd0;
    end else begin
      cnt <= cnt + 1'b1;
      tcnt <= (tcnt == TL) ? '0 : tcnt + 1'b1;
      if (bounce && tcnt == TL) contact <= ~contact;
      if (state == IDLE) begin
        cnt <= '0;
        if (key_valid) begin
          r <= key_code[3:2];
          c <= key_code[1:0];
          tcnt <= '0;
          contact <= 1'b1;
          state <= (BOUNCE_CYC == 0) ? HOLD : BIN;
        end
      end else if (cancel && state != GAP) begin
        state <= GAP;
        cnt <= '0;
        contact <= 1'b0;
      end else if (last) begin
        state <= nxt;
        cnt <= '0;
        tcnt <= '0;
        contact <= state == BIN;
      end
    end
  end
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: randomized self-checking bench for keypad_emulator against a press-timeline model
module tb_keypad_emulator;
  localparam int BP[3] = '{0, 4, 5};
  localparam int HP[3] = '{8, 8, 3};
  localparam int GP[3] = '{4, 4, 2};
  localparam int TP[3] = '{1, 1, 2};
  logic clk = 1'b0;
  logic rst[3], kv[3], cn[3], rdy[3], bsy[3], dn[3];
  logic [3:0] kcode[3], v[3], h[3];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  keypad_emulator #(.HOLD_CYC(8), .GAP_CYC(4), .BOUNCE_CYC(0), .BOUNCE_TOGGLE(1), .CW(8)) u0 (
    .CLK(clk), .RST(rst[0]), .key_valid(kv[0]), .key_code(kcode[0]), .key_ready(rdy[0]),
    .cancel(cn[0]), .V(v[0]), .H(h[0]), .busy(bsy[0]), .done(dn[0]));
  keypad_emulator #(.HOLD_CYC(8), .GAP_CYC(4), .BOUNCE_CYC(4), .BOUNCE_TOGGLE(1), .CW(8)) u1 (
    .CLK(clk), .RST(rst[1]), .key_valid(kv[1]), .key_code(kcode[1]), .key_ready(rdy[1]),
    .cancel(cn[1]), .V(v[1]), .H(h[1]), .busy(bsy[1]), .done(dn[1]));
  keypad_emulator #(.HOLD_CYC(3), .GAP_CYC(2), .BOUNCE_CYC(5), .BOUNCE_TOGGLE(2), .CW(8)) u2 (
    .CLK(clk), .RST(rst[2]), .key_valid(kv[2]), .key_code(kcode[2]), .key_ready(rdy[2]),
    .cancel(cn[2]), .V(v[2]), .H(h[2]), .busy(bsy[2]), .done(dn[2]));
  task automatic chk(input string tag, input logic [3:0] o, input logic [3:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  // Contact level k cycles after accept: bounce-in starts closed, release bounce starts open.
  function automatic bit exp_c(input int i, input int k, input int kc);
    int b = BP[i], hd = HP[i], t = TP[i];
    if (kc > 0 && k > kc) return 1'b0;
    if (k >= 1 && k <= b) return ((k - 1) / t) % 2 == 0;
    if (k > b && k <= b + hd) return 1'b1;
    if (k > b + hd && k <= 2 * b + hd) return ((k - b - hd - 1) / t) % 2 == 1;
    return 1'b0;
  endfunction
  function automatic logic [3:0] exp_h(input bit ct, input logic [3:0] vv, input logic [3:0] code);
    logic [3:0] one = 4'b0001;
    return (ct && !vv[code[3:2]]) ? ~(one << code[1:0]) : 4'hF;
  endfunction
  task automatic idle_chk(input int i, input string tag);
    chk($sformatf("%s_ready%0d", tag, i), {3'b0, rdy[i]}, 4'd1);
    chk($sformatf("%s_busy%0d", tag, i), {3'b0, bsy[i]}, 4'd0);
    chk($sformatf("%s_done%0d", tag, i), {3'b0, dn[i]}, 4'd0);
    chk($sformatf("%s_h%0d", tag, i), h[i], 4'hF);
  endtask
  // Called just after a negedge with instance i idle; presents code, runs the key to completion.
  task automatic do_key(input int i, input logic [3:0] code, input int kc, input int rk,
                        input bit hold, input int vm);
    int fin, ga;
    logic [3:0] vv, one;
    one = 4'b0001;
    fin = kc > 0 ? kc + GP[i] : 2 * BP[i] + HP[i] + GP[i];
    ga = kc > 0 ? kc + 1 : 2 * BP[i] + HP[i] + 1;
    kv[i] = 1'b1;
    kcode[i] = code;
    cn[i] = 1'($urandom % 2);
    #1;
    chk($sformatf("accept_ready%0d", i), {3'b0, rdy[i]}, 4'd1);
    for (int k = 1; k <= fin; k++) begin
      @(negedge clk);
      vv = vm == 1 ? ~(one << (k % 4)) : vm == 2 ? 4'b1110 : vm == 3 ? ((k % 2) ? 4'h0 : 4'hF) : 4'($urandom);
      v[i] = vv;
      if (!hold) kv[i] = 1'($urandom % 2);
      kcode[i] = 4'($urandom);
      cn[i] = (k == kc) || (k >= ga && ($urandom % 2) == 1);
      #1;
      chk($sformatf("h%0d_k%0d", i, k), h[i], exp_h(exp_c(i, k, kc), vv, code));
      chk($sformatf("done%0d_k%0d", i, k), {3'b0, dn[i]}, {3'b0, k == fin});
      chk($sformatf("ready%0d_k%0d", i, k), {3'b0, rdy[i]}, 4'd0);
      chk($sformatf("busy%0d_k%0d", i, k), {3'b0, bsy[i]}, 4'd1);
      if (k == rk) begin
        rst[i] = 1'b1;
        @(negedge clk);
        v[i] = 4'h0;
        kv[i] = 1'b0;
        cn[i] = 1'b0;
        rst[i] = 1'b0;
        #1;
        idle_chk(i, "midrst");
        return;
      end
    end
    @(negedge clk);
    kv[i] = hold;
    cn[i] = 1'b0;
    #1;
    idle_chk(i, "after");
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      kv[i] = 1'b0;
      cn[i] = 1'b0;
      kcode[i] = 4'h0;
      v[i] = 4'hF;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) idle_chk(i, "reset");
    do_key(0, 4'b0110, 0, 0, 0, 1);
    do_key(0, 4'($urandom), 0, 0, 0, 0);
    do_key(0, 4'($urandom), 3, 0, 0, 0);
    do_key(0, 4'b0110, 0, 5, 0, 1);
    do_key(0, 4'b0110, 0, 0, 0, 1);
    do_key(0, 4'h0, 0, 0, 1, 0);
    do_key(0, 4'hF, 0, 0, 0, 0);
    do_key(0, 4'h9, 0, 0, 0, 3);
    do_key(1, 4'h3, 0, 0, 0, 2);
    do_key(1, 4'h3, 4 + 3, 0, 0, 2);
    for (int i = 1; i < 3; i++)
      for (int n = 0; n < 6; n++)
        do_key(i, 4'($urandom), ($urandom % 2) ? int'($urandom_range(1, 2 * BP[i] + HP[i])) : 0,
               0, (n < 5) ? bit'($urandom % 2) : 1'b0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
